// File: rtl/a2d_arbiter.sv
// Two-requester arbiter and sequencer for the shared A2D converter, with timeout guard.
// Optional: define A2D_RES_INV_EN to bitwise-invert captured converter results.
module a2d_arbiter #(
    parameter int unsigned MAX_CONSEC     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_strt,
    input  logic [2:0]  req0_chnnl,
    output logic        req0_done,
    output logic [11:0] req0_res,
    input  logic        req1_strt,
    input  logic [2:0]  req1_chnnl,
    output logic        req1_done,
    output logic [11:0] req1_res,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] A2D_res,
    output logic        busy,
    output logic        timeout_err,
    input  logic        clr_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CW = $clog2(MAX_CONSEC + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t        state;
    logic [1:0]    pend;
    logic [2:0]    ch0, ch1;
    logic [CW-1:0] cnt0;
    logic          gnt;
    logic [TW-1:0] tmr;
    logic          cmplt_q;
    logic          tmo_hit;
    logic          grant0, grant1;
    logic          cmplt_rise, tmo_now;
    logic [11:0]   conv_res;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (pend[1] && (!pend[0] || cnt0 >= CW'(MAX_CONSEC)))
                grant1 = 1'b1;
            else if (pend[0])
                grant0 = 1'b1;
        end
    end

    assign cmplt_rise = (state == WAIT) && cnv_cmplt && !cmplt_q;
    assign tmo_now    = (state == WAIT) && !cmplt_rise && (tmr == TW'(TIMEOUT_CYCLES));

`ifdef A2D_RES_INV_EN
    assign conv_res = ~A2D_res;
`else
    assign conv_res = A2D_res;
`endif

    // A new pulse wins over a same-cycle grant so the request becomes a follow-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            ch0  <= '0;
            ch1  <= '0;
            cnt0 <= '0;
        end else begin
            if (req0_strt) begin
                pend[0] <= 1'b1;
                ch0     <= req0_chnnl;
            end else if (grant0) begin
                pend[0] <= 1'b0;
            end
            if (req1_strt) begin
                pend[1] <= 1'b1;
                ch1     <= req1_chnnl;
            end else if (grant1) begin
                pend[1] <= 1'b0;
            end
            if (!pend[1] || grant1)
                cnt0 <= '0;
            else if (grant0 && cnt0 != CW'(MAX_CONSEC))
                cnt0 <= cnt0 + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= 1'b0;
            chnnl       <= '0;
            strt_cnv    <= 1'b0;
            busy        <= 1'b0;
            cmplt_q     <= 1'b0;
            tmr         <= '0;
            tmo_hit     <= 1'b0;
            req0_done   <= 1'b0;
            req1_done   <= 1'b0;
            req0_res    <= '0;
            req1_res    <= '0;
            timeout_err <= 1'b0;
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            if (clr_err)
                timeout_err <= 1'b0;
            else if (tmo_now)
                timeout_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        state    <= START;
                        gnt      <= grant1;
                        chnnl    <= grant1 ? ch1 : ch0;
                        strt_cnv <= 1'b1;
                        busy     <= 1'b1;
                        cmplt_q  <= 1'b0;
                    end
                end
                START: begin
                    // Sampling the level here means a stale high is not seen as completion.
                    strt_cnv <= 1'b0;
                    cmplt_q  <= cnv_cmplt;
                    tmr      <= '0;
                    tmo_hit  <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    cmplt_q <= cnv_cmplt;
                    if (cmplt_rise) begin
                        state <= DONE;
                    end else if (tmo_now) begin
                        tmo_hit <= 1'b1;
                        state   <= DONE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                DONE: begin
                    if (gnt) begin
                        req1_res  <= tmo_hit ? 12'hFFF : conv_res;
                        req1_done <= 1'b1;
                    end else begin
                        req0_res  <= tmo_hit ? 12'hFFF : conv_res;
                        req0_done <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_arbiter.sv
// Scoreboard bench for a2d_arbiter: driver/converter model pushes expectations, monitor pops and compares.
module tb_a2d_arbiter;

    localparam int MAX_CONSEC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_strt, req1_strt;
    logic [2:0]  req0_chnnl, req1_chnnl;
    logic        req0_done, req1_done;
    logic [11:0] req0_res, req1_res;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] A2D_res;
    logic        busy, timeout_err, clr_err;
    logic [31:0] outs;

    a2d_arbiter #(.MAX_CONSEC(4), .TIMEOUT_CYCLES(1023)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_strt(req0_strt), .req0_chnnl(req0_chnnl), .req0_done(req0_done), .req0_res(req0_res),
        .req1_strt(req1_strt), .req1_chnnl(req1_chnnl), .req1_done(req1_done), .req1_res(req1_res),
        .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res),
        .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    assign outs = {strt_cnv, chnnl, req0_done, req0_res, req1_done, req1_res, busy, timeout_err};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: pending requests, latest channels, req0 streak while req1 waits.
    bit          m_pend[2];
    logic [2:0]  m_ch[2];
    int          m_streak;
    logic [11:0] m_last[2];
    bit          active;
    int          cur_g;
    bit          done_ok;
    bit          strt_prev;

    logic [2:0]  exp_start[$];
    logic [12:0] exp_done[$];
    int          done_log[$];
    int          exp_order[6] = '{0, 0, 0, 0, 1, 0};

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [11:0] xform(input logic [11:0] v);
`ifdef A2D_RES_INV_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic predict_grant();
        int g;
        g = -1;
        if (m_pend[1] && (!m_pend[0] || m_streak >= MAX_CONSEC)) g = 1;
        else if (m_pend[0]) g = 0;
        if (!m_pend[1] || g == 1) m_streak = 0;
        else if (g == 0) m_streak++;
        active = (g >= 0);
        if (active) begin
            cur_g = g;
            m_pend[g] = 1'b0;
            exp_start.push_back(m_ch[g]);
        end
    endtask

    task automatic issue(input bit p0, input logic [2:0] c0, input bit p1, input logic [2:0] c1);
        req0_strt = p0; req0_chnnl = c0;
        req1_strt = p1; req1_chnnl = c1;
        if (p0) begin m_pend[0] = 1'b1; m_ch[0] = c0; end
        if (p1) begin m_pend[1] = 1'b1; m_ch[1] = c1; end
        @(negedge clk);
        req0_strt = 1'b0;
        req1_strt = 1'b0;
    endtask

    task automatic reset_model();
        m_pend[0] = 1'b0; m_pend[1] = 1'b0;
        m_ch[0] = '0; m_ch[1] = '0;
        m_last[0] = '0; m_last[1] = '0;
        m_streak = 0;
        active = 1'b0;
    endtask

    // mode 0: random pulses, 1: req0 re-requests on ch 1, 2: req1 ch 2 then ch 5.
    task automatic convert(input int mode, input int n_req, input bit stale, input bit tmo,
                           input int dly, input bit use_val, input logic [11:0] val);
        int cyc;
        int g;
        int lat;
        time t0;
        logic [11:0] v, e;
        logic [1:0] r;
        g = cur_g;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!strt_cnv && cyc < 8);
        chk("start_latency", 32'(cyc), 32'd1);
        t0 = $time;
        if (stale) repeat (3) @(negedge clk);
        cnv_cmplt = 1'b0;
        if (mode == 2) begin
            issue(1'b0, 3'd0, 1'b1, 3'd2);
            issue(1'b0, 3'd0, 1'b1, 3'd5);
        end else begin
            for (int i = 0; i < n_req; i++) begin
                if (mode == 1) issue(1'b1, 3'd1, 1'b0, 3'd0);
                else begin
                    r = 2'($urandom_range(0, 3));
                    issue(r[0], 3'($urandom), r[1], 3'($urandom));
                end
            end
        end
        v = use_val ? val : 12'($urandom);
        e = tmo ? 12'hFFF : xform(v);
        exp_done.push_back({g[0], e});
        m_last[g] = e;
        predict_grant();
        if (!tmo) begin
            repeat (dly) @(negedge clk);
            A2D_res = v;
            cnv_cmplt = 1'b1;
            done_ok = 1'b1;
            cyc = 0;
            do begin @(negedge clk); cyc++; end while (!(req0_done || req1_done) && cyc < 8);
            chk("done_latency", 32'(cyc), 32'd2);
        end else begin
            done_ok = 1'b1;
            cyc = 0;
            do begin @(negedge clk); cyc++; end while (!(req0_done || req1_done) && cyc < 1100);
            lat = int'(($time - t0) / 10);
            n_cmp++;
            if (lat < 1024 || lat > 1026) begin
                n_bad++;
                $display("FAIL timeout_latency: got %0d cycles required 1024..1026", lat);
            end
            chk("timeout_flag", 32'(timeout_err), 32'd1);
            cnv_cmplt = 1'b1;
        end
    endtask

    // Monitor: every start and done is matched against the scoreboard queues.
    initial begin
        logic [12:0] e;
        int g;
        strt_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (strt_cnv) begin
                chk("strt_one_cycle", 32'(strt_prev), 32'd0);
                chk("busy_in_start", 32'(busy), 32'd1);
                chk("start_expected", 32'(exp_start.size() != 0), 32'd1);
                if (exp_start.size() != 0) chk("start_chnnl", 32'(chnnl), 32'(exp_start.pop_front()));
            end
            if (req0_done || req1_done) begin
                chk("done_exclusive", 32'(req0_done && req1_done), 32'd0);
                chk("done_allowed", 32'(done_ok), 32'd1);
                done_ok = 1'b0;
                g = req1_done ? 1 : 0;
                done_log.push_back(g);
                chk("done_expected", 32'(exp_done.size() != 0), 32'd1);
                if (exp_done.size() != 0) begin
                    e = exp_done.pop_front();
                    chk("done_id", 32'(g), 32'(e[12]));
                    chk("done_res", 32'(g ? req1_res : req0_res), 32'(e[11:0]));
                end
                chk("other_res_held", 32'(g ? req0_res : req1_res), 32'(m_last[1-g]));
            end
            strt_prev = strt_cnv;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        logic [1:0] r;
        rst_n = 1'b0; req0_strt = 1'b0; req1_strt = 1'b0;
        req0_chnnl = '0; req1_chnnl = '0;
        cnv_cmplt = 1'b1; A2D_res = '0; clr_err = 1'b0;
        done_ok = 1'b0; cur_g = 0;
        reset_model();
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request, 256-cycle conversion.
        issue(1'b1, 3'd3, 1'b0, 3'd0); predict_grant();
        convert(0, 0, 1'b0, 1'b0, 256, 1'b1, 12'h5A3);
        chk("single_res0", 32'(req0_res), 32'(xform(12'h5A3)));
        chk("single_res1", 32'(req1_res), 32'd0);

        // Simultaneous requests: req0 first, then req1.
        done_log.delete();
        issue(1'b1, 3'd1, 1'b1, 3'd6); predict_grant();
        convert(0, 0, 1'b0, 1'b0, 3, 1'b0, 12'h0);
        convert(0, 0, 1'b0, 1'b0, 3, 1'b0, 12'h0);
        chk("simul_count", 32'(done_log.size()), 32'd2);
        if (done_log.size() == 2) begin
            chk("simul_first", 32'(done_log[0]), 32'd0);
            chk("simul_second", 32'(done_log[1]), 32'd1);
        end

        // Starvation guard.
        done_log.delete();
        issue(1'b1, 3'd1, 1'b1, 3'd6); predict_grant();
        repeat (5) convert(1, 1, 1'b0, 1'b0, 4, 1'b0, 12'h0);
        convert(0, 0, 1'b0, 1'b0, 2, 1'b0, 12'h0);
        chk("starve_count", 32'(done_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < done_log.size(); i++)
            chk("starve_order", 32'(done_log[i]), 32'(exp_order[i]));

        // Overwrite while pending plus stale completion level.
        issue(1'b1, 3'd3, 1'b0, 3'd0); predict_grant();
        convert(2, 0, 1'b1, 1'b0, 6, 1'b0, 12'h0);
        convert(0, 0, 1'b1, 1'b0, 4, 1'b0, 12'h0);
        chk("overwrite_idle", 32'(active), 32'd0);

        // Result inversion vector.
        issue(1'b1, 3'd2, 1'b0, 3'd0); predict_grant();
        convert(0, 0, 1'b0, 1'b0, 3, 1'b1, 12'h0F0);
        chk("inv_res", 32'(req0_res), 32'(xform(12'h0F0)));

        // Timeout with converter stuck low, then clear.
        issue(1'b0, 3'd0, 1'b1, 3'd4); predict_grant();
        convert(0, 0, 1'b0, 1'b1, 0, 1'b0, 12'h0);
        chk("timeout_res", 32'(req1_res), 32'hFFF);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("timeout_clr", 32'(timeout_err), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            if (!active) begin
                r = 2'($urandom_range(1, 3));
                issue(r[0], 3'($urandom), r[1], 3'($urandom));
                predict_grant();
            end
            convert(0, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 1'b0,
                    $urandom_range(1, 20), 1'b0, 12'h0);
        end
        for (int n = 0; n < 3; n++)
            if (active) convert(0, 0, 1'b0, 1'b0, 2, 1'b0, 12'h0);

        // Reset during WAIT: silent abort.
        issue(1'b1, 3'd7, 1'b1, 3'd2); predict_grant();
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!strt_cnv && cyc < 8);
        chk("rst_test_start", 32'(strt_cnv), 32'd1);
        cnv_cmplt = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_test_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("rst_mid_outputs", outs, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        cnv_cmplt = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_stays_idle", 32'(busy), 32'd0);

        chk("drain_start", 32'(exp_start.size()), 32'd0);
        chk("drain_done", 32'(exp_done.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
